fir_decim_requant: RTL and testbench

Downstream stage of the FIR filter. Takes the filter's full-precision signed output (WIDTH+3 bits), keeps one sample in every DECIM, and requantizes it back to WIDTH bits by rounding and saturating. Results are buffered in a small FIFO and presented on a valid/ready stream to the capture/DMA logic.

---
 rtl/fir_pkg.sv | 50 +++++
 rtl/fir_sync_fifo.sv | 79 +++++++
 rtl/fir_decim_requant.sv | 130 +++++++++++++
 tb/tb_fir_decim_requant.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR filter back end.
//   FIR_WIDTH    : default output sample width
//   in_sample_t  : full-precision filter output (FIR_WIDTH+3 bits, signed)
//   out_sample_t : requantized sample (FIR_WIDTH bits, signed)
//   rs_t         : round_sat result (value + saturation bit)
//   round_sat    : round-half-up right shift followed by saturation
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int FIR_WIDTH = 16;

  typedef logic signed [FIR_WIDTH+2:0] in_sample_t;
  typedef logic signed [FIR_WIDTH-1:0] out_sample_t;

  // value is always inside the signed range of 'width' bits, so callers
  // can simply truncate it to their own sample width.
  typedef struct packed {
    logic signed [63:0] value;
    logic               sat;
  } rs_t;

  // x must already be sign-extended to 64 bits. The 64-bit working width
  // comfortably holds x + 2^(shift-1) for any legal width/shift, so the
  // rounding add can never overflow.
  function automatic rs_t round_sat(input logic signed [63:0] x,
                                    input int width,
                                    input int shift);
    rs_t                res;
    logic signed [63:0] r;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    r     = (x + (64'sd1 <<< (shift - 1))) >>> shift;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (r > max_v) begin
      res.value = max_v;
      res.sat   = 1'b1;
    end else if (r < min_v) begin
      res.value = min_v;
      res.sat   = 1'b1;
    end else begin
      res.value = r;
      res.sat   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// -----------------------------------------------------------------------------
// fir_sync_fifo
// Single-clock FIFO with synchronous active-high reset.
//   clk_i    : clock (rising edge)
//   rst_i    : synchronous active-high reset, empties the FIFO
//   push_i   : write wdata_i; honoured when not full, or when full and a pop
//              happens in the same cycle
//   wdata_i  : write data
//   pop_i    : remove the head entry; ignored when empty
//   rdata_o  : head entry (reads 0 while empty)
//   full_o   : count == DEPTH
//   empty_o  : count == 0
//   count_o  : number of stored entries
// A push that cannot be honoured is silently ignored; deciding what that
// means for the system is left to the instantiating block.
// -----------------------------------------------------------------------------
module fir_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing is read from it while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fir_decim_requant.sv
// -----------------------------------------------------------------------------
// fir_decim_requant
// Keeps one in every DECIM filter outputs, requantizes it from WIDTH+3 to
// WIDTH bits (round-half-up shift by SHIFT, then saturate), and queues the
// result for the capture/DMA logic.
//   CLK       : clock (rising edge)
//   rst       : synchronous active-high reset
//   in_valid  : in_data carries a filter output this cycle (no back-pressure)
//   in_data   : signed filter output, WIDTH+3 bits
//   out_valid : FIFO head is valid
//   out_ready : consumer takes the head this cycle
//   out_data  : signed requantized sample at the FIFO head
//   sat_flag  : sticky, some kept sample saturated
//   drop_flag : sticky, some kept sample was lost because the FIFO was full
//
// Output handshake: a sample transfers on every rising edge where
// out_valid=1 and out_ready=1. out_valid depends only on FIFO occupancy,
// never on out_ready, and out_data is stable while out_valid=1 and
// out_ready=0. out_data has no meaning while out_valid=0.
// -----------------------------------------------------------------------------
module fir_decim_requant #(
  parameter int WIDTH      = fir_pkg::FIR_WIDTH,
  parameter int DECIM      = 4,
  parameter int SHIFT      = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH+2:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    sat_flag,
  output logic                    drop_flag
);

  import fir_pkg::*;

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Phase counter: advances only on valid inputs, so idle gaps do not
  // disturb the decimation pattern.
  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;
  logic          keep;

  assign keep = in_valid && (phase_q == '0);

  always_comb begin
    phase_d = phase_q;
    if (in_valid) begin
      if (phase_q == PW'(DECIM - 1)) phase_d = '0;
      else                           phase_d = phase_q + PW'(1);
    end
  end

  // Requantization of the current input (used only when kept).
  rs_t rs;
  always_comb rs = round_sat(64'(in_data), WIDTH, SHIFT);

  // Stage register between requantizer and FIFO.
  logic                    stage_valid_q;
  logic                    stage_valid_d;
  logic signed [WIDTH-1:0] stage_data_q;
  logic signed [WIDTH-1:0] stage_data_d;

  assign stage_valid_d = keep;
  assign stage_data_d  = WIDTH'(rs.value);

  // FIFO interface.
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [WIDTH-1:0] fifo_rdata;

  assign fifo_pop  = out_ready & ~fifo_empty;
  assign fifo_push = stage_valid_q & (~fifo_full | fifo_pop);

  // Sticky flags.
  logic sat_q;
  logic sat_d;
  logic drop_q;
  logic drop_d;

  // Only kept samples may saturate the flag.
  assign sat_d  = sat_q | (keep & rs.sat);
  // A staged sample is lost when the FIFO is full and nothing leaves.
  assign drop_d = drop_q | (stage_valid_q & fifo_full & ~fifo_pop);

  always_ff @(posedge CLK) begin
    if (rst) begin
      phase_q       <= '0;
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      sat_q         <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      stage_valid_q <= stage_valid_d;
      stage_data_q  <= stage_data_d;
      sat_q         <= sat_d;
      drop_q        <= drop_d;
    end
  end

  fir_sync_fifo #(
    .W     (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .wdata_i (stage_data_q),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_data  = fifo_rdata;
  assign sat_flag  = sat_q;
  assign drop_flag = drop_q;

endmodule

// File: tb/tb_fir_decim_requant.sv
module tb_fir_decim_requant;

  localparam int W     = 16;
  localparam int IW    = W + 3;
  localparam int SH    = 3;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // DUT with DECIM=1 (suffix 1) and DECIM=4 (suffix 4)
  logic          v1, r1, ov1, sat1, drop1;
  logic [IW-1:0] d1;
  logic [W-1:0]  od1;
  logic          v4, r4, ov4, sat4, drop4;
  logic [IW-1:0] d4;
  logic [W-1:0]  od4;

  int n_tests = 0;
  int n_fail  = 0;

  fir_decim_requant #(.WIDTH(W), .DECIM(1), .SHIFT(SH), .FIFO_DEPTH(DEPTH)) u_d1 (
    .CLK(clk), .rst(rst), .in_valid(v1), .in_data(d1), .out_valid(ov1),
    .out_ready(r1), .out_data(od1), .sat_flag(sat1), .drop_flag(drop1));

  fir_decim_requant #(.WIDTH(W), .DECIM(4), .SHIFT(SH), .FIFO_DEPTH(DEPTH)) u_d4 (
    .CLK(clk), .rst(rst), .in_valid(v4), .in_data(d4), .out_valid(ov4),
    .out_ready(r4), .out_data(od4), .sat_flag(sat4), .drop_flag(drop4));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- reference arithmetic ----------------
  // floor((x + 2^(SH-1)) / 2^SH) with ordinary integer division
  function automatic int rq_raw(input int x);
    int t;
    t = x + (1 << (SH - 1));
    if (t >= 0) return t / (1 << SH);
    return -((-t + (1 << SH) - 1) / (1 << SH));
  endfunction

  function automatic int rq_val(input int x);
    int r;
    r = rq_raw(x);
    if (r > 32767)  return 32767;
    if (r < -32768) return -32768;
    return r;
  endfunction

  function automatic bit rq_sat(input int x);
    int r;
    r = rq_raw(x);
    return (r > 32767) || (r < -32768);
  endfunction

  // ---------------- scoreboard model for DECIM=1 DUT ----------------
  logic [W-1:0] exp_q[$];
  logic         m_sv   = 1'b0;
  logic [W-1:0] m_sval = '0;
  logic         m_sat  = 1'b0;
  logic         m_drop = 1'b0;

  task automatic model_update();
    int occ;
    bit pop;
    int x;
    if (rst) begin
      exp_q.delete();
      m_sv = 1'b0; m_sval = '0; m_sat = 1'b0; m_drop = 1'b0;
    end else begin
      occ = exp_q.size();
      pop = (occ != 0) && r1;
      if (pop) void'(exp_q.pop_front());
      if (m_sv) begin
        if (occ < DEPTH || pop) exp_q.push_back(m_sval);
        else m_drop = 1'b1;
      end
      x    = int'($signed(d1));
      m_sv = v1;
      if (v1) begin
        m_sval = W'(rq_val(x));
        if (rq_sat(x)) m_sat = 1'b1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; outputs are observed at the following negedge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v1 = 1'b0; d1 = '0; r1 = 1'b0;
    v4 = 1'b0; d4 = '0; r4 = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    v1 = 1'b1; d1 = IW'(1234); r1 = 1'b1;
    v4 = 1'b1; d4 = IW'(1234); r4 = 1'b1;
    tick(); tick();
    n_tests++; if (ov1 !== 1'b0)   begin n_fail++; $display("FAIL reset_ov1: got %b exp 0", ov1); end
    n_tests++; if (od1 !== '0)     begin n_fail++; $display("FAIL reset_od1: got %0d exp 0", od1); end
    n_tests++; if (sat1 !== 1'b0)  begin n_fail++; $display("FAIL reset_sat1: got %b exp 0", sat1); end
    n_tests++; if (drop1 !== 1'b0) begin n_fail++; $display("FAIL reset_drop1: got %b exp 0", drop1); end
    n_tests++; if (ov4 !== 1'b0)   begin n_fail++; $display("FAIL reset_ov4: got %b exp 0", ov4); end
    n_tests++; if (od4 !== '0)     begin n_fail++; $display("FAIL reset_od4: got %0d exp 0", od4); end
    n_tests++; if (sat4 !== 1'b0)  begin n_fail++; $display("FAIL reset_sat4: got %b exp 0", sat4); end
    n_tests++; if (drop4 !== 1'b0) begin n_fail++; $display("FAIL reset_drop4: got %b exp 0", drop4); end
    rst = 1'b0; v1 = 1'b0; v4 = 1'b0; r1 = 1'b0; r4 = 1'b0;
  endtask

  task automatic test_rounding();
    int vals[4] = '{100, -100, 4, -4};
    int expv[4] = '{13, -12, 1, 0};
    do_reset();
    r1 = 1'b1;
    for (int j = 0; j < 7; j++) begin
      v1 = (j < 4);
      d1 = (j < 4) ? IW'(vals[j]) : '0;
      tick();
      if (j >= 1 && j <= 4) begin
        n_tests++; if (ov1 !== 1'b1) begin n_fail++; $display("FAIL round_valid[%0d]: got %b exp 1", j, ov1); end
        n_tests++; if (od1 !== W'(expv[j-1])) begin
          n_fail++; $display("FAIL round_data[%0d]: got %0d exp %0d", j, $signed(od1), expv[j-1]);
        end
      end else begin
        n_tests++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL round_idle[%0d]: got %b exp 0", j, ov1); end
      end
    end
    n_tests++; if (sat1 !== 1'b0)  begin n_fail++; $display("FAIL round_sat: got %b exp 0", sat1); end
    n_tests++; if (drop1 !== 1'b0) begin n_fail++; $display("FAIL round_drop: got %b exp 0", drop1); end
  endtask

  task automatic test_saturation();
    do_reset();
    r1 = 1'b1;
    v1 = 1'b1; d1 = IW'(262143);
    tick();
    n_tests++; if (sat1 !== 1'b1) begin n_fail++; $display("FAIL sat_rise: got %b exp 1", sat1); end
    v1 = 1'b1; d1 = IW'(-262144);
    tick();
    n_tests++; if (ov1 !== 1'b1 || od1 !== 16'h7fff) begin
      n_fail++; $display("FAIL sat_pos: got v=%b d=%0d exp v=1 d=32767", ov1, $signed(od1));
    end
    v1 = 1'b0;
    tick();
    n_tests++; if (ov1 !== 1'b1 || od1 !== 16'h8000) begin
      n_fail++; $display("FAIL sat_neg: got v=%b d=%0d exp v=1 d=-32768", ov1, $signed(od1));
    end
    n_tests++; if (sat1 !== 1'b1) begin n_fail++; $display("FAIL sat_sticky: got %b exp 1", sat1); end
    tick();
    n_tests++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL sat_empty: got %b exp 0", ov1); end
  endtask

  task automatic test_decimation();
    logic [W-1:0] got[$];
    logic [W-1:0] expd[$];
    int gaps;
    do_reset();
    r4 = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      v4 = 1'b1; d4 = IW'(8 * s);
      if ((s - 1) % 4 == 0) expd.push_back(W'(rq_val(8 * s)));
      tick();
      if (ov4) got.push_back(od4);
      v4 = 1'b0;
      gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) begin
        tick();
        if (ov4) got.push_back(od4);
      end
    end
    for (int g = 0; g < 4; g++) begin
      tick();
      if (ov4) got.push_back(od4);
    end
    n_tests++; if (got.size() != expd.size()) begin
      n_fail++; $display("FAIL decim_count: got %0d exp %0d", got.size(), expd.size());
    end
    for (int i = 0; i < expd.size() && i < got.size(); i++) begin
      n_tests++; if (got[i] !== expd[i]) begin
        n_fail++; $display("FAIL decim_data[%0d]: got %0d exp %0d", i, $signed(got[i]), $signed(expd[i]));
      end
    end
    // Saturating values in non-kept phases must not set the flag.
    v4 = 1'b1; d4 = IW'(8);
    tick();
    for (int s = 0; s < 3; s++) begin
      v4 = 1'b1; d4 = IW'(262143);
      tick();
      v4 = 1'b0;
      tick();
    end
    n_tests++; if (sat4 !== 1'b0) begin n_fail++; $display("FAIL decim_sat_skip: got %b exp 0", sat4); end
    v4 = 1'b1; d4 = IW'(262143);
    tick();
    v4 = 1'b0;
    n_tests++; if (sat4 !== 1'b1) begin n_fail++; $display("FAIL decim_sat_kept: got %b exp 1", sat4); end
    tick(); tick();
  endtask

  task automatic test_overflow();
    do_reset();
    r1 = 1'b0;
    for (int s = 1; s <= 6; s++) begin
      v1 = 1'b1; d1 = IW'(8 * s);
      tick();
      if (s == 5) begin
        n_tests++; if (drop1 !== 1'b0) begin n_fail++; $display("FAIL ovf_no_drop_yet: got %b exp 0", drop1); end
      end
      if (s == 6) begin
        n_tests++; if (drop1 !== 1'b1) begin n_fail++; $display("FAIL ovf_drop_rise: got %b exp 1", drop1); end
      end
    end
    v1 = 1'b0;
    tick(); tick();
    n_tests++; if (ov1 !== 1'b1 || od1 !== W'(1)) begin
      n_fail++; $display("FAIL ovf_hold: got v=%b d=%0d exp v=1 d=1", ov1, $signed(od1));
    end
    r1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (ov1 !== 1'b1 || od1 !== W'(i + 1)) begin
        n_fail++; $display("FAIL ovf_drain[%0d]: got v=%b d=%0d exp v=1 d=%0d", i, ov1, $signed(od1), i + 1);
      end
      tick();
    end
    n_tests++; if (ov1 !== 1'b0)   begin n_fail++; $display("FAIL ovf_empty: got %b exp 0", ov1); end
    n_tests++; if (drop1 !== 1'b1) begin n_fail++; $display("FAIL ovf_drop_sticky: got %b exp 1", drop1); end
  endtask

  task automatic test_full_pop();
    do_reset();
    r1 = 1'b0;
    for (int s = 1; s <= 5; s++) begin
      v1 = 1'b1; d1 = IW'(8 * s);
      tick();
    end
    v1 = 1'b0;
    n_tests++; if (ov1 !== 1'b1 || od1 !== W'(1) || drop1 !== 1'b0) begin
      n_fail++; $display("FAIL fullpop_pre: got v=%b d=%0d drop=%b exp v=1 d=1 drop=0", ov1, $signed(od1), drop1);
    end
    r1 = 1'b1;           // pop while sample 5 is pushed into a full FIFO
    tick();
    r1 = 1'b0;
    tick(); tick();
    n_tests++; if (drop1 !== 1'b0) begin n_fail++; $display("FAIL fullpop_drop: got %b exp 0", drop1); end
    r1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (ov1 !== 1'b1 || od1 !== W'(i + 2)) begin
        n_fail++; $display("FAIL fullpop_order[%0d]: got v=%b d=%0d exp v=1 d=%0d", i, ov1, $signed(od1), i + 2);
      end
      tick();
    end
    n_tests++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty: got %b exp 0", ov1); end
  endtask

  task automatic test_reset_mid();
    int vals[6] = '{262143, 16, 24, 32, 40, 48};
    do_reset();
    r1 = 1'b0;
    for (int s = 0; s < 6; s++) begin
      v1 = 1'b1; d1 = IW'(vals[s]);
      tick();
    end
    v1 = 1'b0;
    tick();
    r1 = 1'b1;
    tick();              // one pop leaves three entries
    r1 = 1'b0;
    n_tests++; if (ov1 !== 1'b1 || sat1 !== 1'b1 || drop1 !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: got v=%b sat=%b drop=%b exp 1 1 1", ov1, sat1, drop1);
    end
    rst = 1'b1; v1 = 1'b1; d1 = IW'(999);
    tick();
    rst = 1'b0; v1 = 1'b0;
    n_tests++; if (ov1 !== 1'b0 || sat1 !== 1'b0 || drop1 !== 1'b0 || od1 !== '0) begin
      n_fail++; $display("FAIL rstmid_clear: got v=%b sat=%b drop=%b d=%0d exp 0 0 0 0", ov1, sat1, drop1, od1);
    end
    v1 = 1'b1; d1 = IW'(80); r1 = 1'b1;
    tick();
    v1 = 1'b0;
    n_tests++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL rstmid_lat1: got %b exp 0", ov1); end
    tick();
    n_tests++; if (ov1 !== 1'b1 || od1 !== W'(10)) begin
      n_fail++; $display("FAIL rstmid_first: got v=%b d=%0d exp v=1 d=10", ov1, $signed(od1));
    end
    tick();
    n_tests++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: got %b exp 0", ov1); end
  endtask

  task automatic test_back_to_back();
    int xs[20];
    do_reset();
    r1 = 1'b1;
    for (int j = 0; j < 22; j++) begin
      if (j < 20) begin
        xs[j] = int'($signed(IW'($urandom_range(0, (1 << IW) - 1))));
        v1 = 1'b1; d1 = IW'(xs[j]);
      end else begin
        v1 = 1'b0;
      end
      tick();
      if (j >= 1 && j <= 20) begin
        n_tests++; if (ov1 !== 1'b1 || od1 !== W'(rq_val(xs[j-1]))) begin
          n_fail++; $display("FAIL b2b[%0d]: got v=%b d=%0d exp v=1 d=%0d", j, ov1, $signed(od1), rq_val(xs[j-1]));
        end
      end
    end
    n_tests++; if (ov1 !== 1'b0)  begin n_fail++; $display("FAIL b2b_empty: got %b exp 0", ov1); end
    n_tests++; if (sat1 !== m_sat) begin n_fail++; $display("FAIL b2b_sat: got %b exp %b", sat1, m_sat); end
    n_tests++; if (drop1 !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: got %b exp 0", drop1); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      v1 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) d1 = IW'($urandom_range(0, (1 << IW) - 1));
      else                           d1 = IW'(int'($urandom_range(0, 40000)) - 20000);
      r1 = ($urandom_range(0, 9) < 4);
      tick();
      n_tests++; if (ov1 !== (exp_q.size() != 0)) begin
        n_fail++; $display("FAIL rand_valid[%0d]: got %b exp %b", c, ov1, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        n_tests++; if (od1 !== exp_q[0]) begin
          n_fail++; $display("FAIL rand_data[%0d]: got %0d exp %0d", c, $signed(od1), $signed(exp_q[0]));
        end
      end
      n_tests++; if (sat1 !== m_sat)   begin n_fail++; $display("FAIL rand_sat[%0d]: got %b exp %b", c, sat1, m_sat); end
      n_tests++; if (drop1 !== m_drop) begin n_fail++; $display("FAIL rand_drop[%0d]: got %b exp %b", c, drop1, m_drop); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    v1 = 1'b0; d1 = '0; r1 = 1'b0;
    v4 = 1'b0; d4 = '0; r4 = 1'b0;
    @(negedge clk);
    test_reset();
    test_rounding();
    test_saturation();
    test_decimation();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
